// File: rtl/seven_segment_reader.sv
// Decodes a multiplexed active-low seven-segment bus back into per-digit values.
// Optional ghost-event counter: define SEVEN_SEGMENT_READER_GHOST_CNT_EN.
module seven_segment_reader #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    display_off,
  output logic [7:0]              ghost_cnt
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0]            seg_s1, seg_s2, seg_p;
  logic [NUM_DIGITS-1:0] en_s1, en_s2, en_p;
  logic [SW-1:0]         stab_cnt;
  logic [IW-1:0]         idle_cnt;
  logic [NUM_DIGITS-1:0] seen_mask;

  logic                  same, at_capture, one_low, capture, ghost;
  logic                  all_idle, timeout, frame_done;
  logic [NUM_DIGITS-1:0] low, next_mask;
  logic [4:0]            dec;

  // Returns {unrecognised, value}; inverse of the team digit encoder.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b1101111: decode = 5'h0E;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    low        = ~en_s2;
    same       = ({seg_s2, en_s2} == {seg_p, en_p});
    at_capture = same && (stab_cnt == SW'(STABLE_CYCLES - 2));
    one_low    = (low != '0) && ((low & (low - NUM_DIGITS'(1))) == '0);
    capture    = at_capture && one_low;
    ghost      = at_capture && !one_low && (low != '0);
    all_idle   = &en_s2;
    timeout    = all_idle && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
    next_mask  = seen_mask | low;
    frame_done = capture && (&next_mask);
    dec        = decode(seg_s2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
      en_s1  <= '1;
      en_s2  <= '1;
      en_p   <= '1;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
      en_s1  <= digit_en_n;
      en_s2  <= en_s1;
      en_p   <= en_s2;
    end
  end

  // Counter saturates at STABLE_CYCLES-1, so the capture point is only crossed once per pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (!same) begin
      stab_cnt <= '0;
    end else if (stab_cnt != SW'(STABLE_CYCLES - 1)) begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= '0;
      display_off <= 1'b0;
    end else if (!all_idle) begin
      idle_cnt    <= '0;
      display_off <= 1'b0;
    end else begin
      if (idle_cnt != IW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + IW'(1);
      if (timeout) display_off <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '1;
      digit_err   <= '0;
      seen_mask   <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (timeout || frame_done) seen_mask <= '0;
      else if (capture)          seen_mask <= next_mask;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture && low[i]) begin
          digit_err[i] <= dec[4];
          if (!dec[4]) digits[4*i +: 4] <= dec[3:0];
        end
      end
    end
  end

`ifdef SEVEN_SEGMENT_READER_GHOST_CNT_EN
  logic [7:0] ghost_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghost_q <= '0;
    end else if (ghost && (ghost_q != 8'hFF)) begin
      ghost_q <= ghost_q + 8'd1;
    end
  end

  assign ghost_cnt = ghost_q;
`else
  logic unused_ghost;
  assign unused_ghost = ghost;
  assign ghost_cnt    = '0;
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed self-checking bench for seven_segment_reader (4 digits, short timeout).
module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam int SC = 8;
  localparam int TO = 400;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, SE = 7'b1101111, SB = 7'b1111111;
  localparam logic [6:0] SBAD = 7'b0101010;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      seg_in;
  logic [ND-1:0]   digit_en_n;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_err;
  logic            frame_valid;
  logic            display_off;
  logic [7:0]      ghost_cnt;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;
  int fv_base;
  logic [7:0] ghost_exp;

  seven_segment_reader #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .digit_en_n (digit_en_n),
    .digits     (digits),
    .digit_err  (digit_err),
    .frame_valid(frame_valid),
    .display_off(display_off),
    .ghost_cnt  (ghost_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the n-th following edge.
  task automatic show(input logic [ND-1:0] en, input logic [6:0] seg, input int n);
    digit_en_n = en;
    seg_in     = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] a, input logic [6:0] b,
                      input logic [6:0] c, input logic [6:0] d);
    show(4'b1110, a, 20);
    show(4'b1101, b, 20);
    show(4'b1011, c, 20);
    show(4'b0111, d, 20);
  endtask

  initial begin
`ifdef SEVEN_SEGMENT_READER_GHOST_CNT_EN
    ghost_exp = 8'd255;
`else
    ghost_exp = 8'd0;
`endif
    rst_n      = 1'b0;
    seg_in     = '1;
    digit_en_n = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", digits, 16'hFFFF);
    chk("rst_err", digit_err, 4'h0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_off", display_off, 1'b0);
    chk("rst_ghost", ghost_cnt, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First scan, with exact capture latency on the final digit
    show(4'b1110, S9, 20);
    show(4'b1101, S6, 20);
    show(4'b1011, S1, 20);
    show(4'b0111, S0, 9);
    chk("lat_pre_digit3", digits[15:12], 4'hF);
    chk("lat_pre_fv", frame_valid, 1'b0);
    show(4'b0111, S0, 1);
    chk("lat_fv_high", frame_valid, 1'b1);
    chk("lat_digits", digits, 16'h0169);
    show(4'b0111, S0, 1);
    chk("lat_fv_low", frame_valid, 1'b0);
    show(4'b0111, S0, 9);
    chk("scan1_fv_cnt", fv_cnt, 1);
    chk("scan1_err", digit_err, 4'h0);

    // Fallback glyph and blank on digit 2
    scan(S9, S6, SE, S0);
    chk("glyph_E", digits, 16'h0E69);
    scan(S9, S6, SB, S0);
    chk("blank_F", digits, 16'h0F69);
    chk("glyph_err", digit_err, 4'h0);
    chk("glyph_fv_cnt", fv_cnt, 3);

    // Unrecognised pattern on digit 1, then a valid 3
    show(4'b1101, SBAD, 20);
    chk("bad_err", digit_err, 4'b0010);
    chk("bad_hold", digits[7:4], 4'h6);
    show(4'b1101, S3, 20);
    chk("bad_clear", digit_err, 4'h0);
    chk("bad_then3", digits, 16'h0F39);

    // Short glitch between valid patterns on digit 0
    show(4'b1110, S5, 20);
    chk("glitch_pre", digits[3:0], 4'h5);
    show(4'b1110, S8, SC - 2);
    for (int k = 0; k < 20; k++) begin
      show(4'b1110, S5, 1);
      chk("glitch_hold", digits[3:0], 4'h5);
    end
    chk("glitch_err", digit_err, 4'h0);

    // Ghost events: two digits enabled together
    fv_base = fv_cnt;
    for (int k = 0; k < 150; k++) begin
      show(4'b1100, S9, 20);
      show(4'b0011, S9, 20);
    end
    chk("ghost_cnt", ghost_cnt, ghost_exp);
    chk("ghost_digits", digits, 16'h0F35);
    chk("ghost_fv", fv_cnt, fv_base);

    // Timeout with digits 0 and 1 already seen in this frame
    show(4'hF, SB, TO + 1);
    chk("to_before", display_off, 1'b0);
    show(4'hF, SB, 1);
    chk("to_edge", display_off, 1'b1);
    chk("to_digits", digits, 16'h0F35);
    fv_base = fv_cnt;
    show(4'b1011, S7, 20);
    chk("to_clear", display_off, 1'b0);
    show(4'b0111, S8, 20);
    show(4'b1110, S2, 20);
    chk("to_partial_fv", fv_cnt, fv_base);
    show(4'b1101, S4, 20);
    chk("to_full_fv", fv_cnt, fv_base + 1);
    chk("to_digits2", digits, 16'h8742);

    // Reset in the middle of a capture
    show(4'b1110, S1, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_digits", digits, 16'hFFFF);
    chk("midrst_fv", frame_valid, 1'b0);
    chk("midrst_ghost", ghost_cnt, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    show(4'b1110, S1, 20);
    chk("midrst_recap", digits, 16'hFFF1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Decodes a multiplexed, active-low seven-segment display bus back into per-digit 4-bit values, so the tester can read what a DUT front panel is showing. It sits between the board input pins and the tester's result logic. It inverts the team's digit-to-segment encoding, including the encoder's fallback glyph. Inputs are synchronised, each digit is qualified by a stability filter, and a pulse flags each complete display scan.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (1–8).
- STABLE_CYCLES, 8: consecutive identical synchronised samples required before capture (≥2).
- TIMEOUT_CYCLES, 100000: idle cycles with no digit enabled before display_off.
- clk  in  1: single clock.
- rst_n  in  1: reset, asynchronous assert, active-low.
- seg_in  in  7: segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- digit_en_n  in  NUM_DIGITS: digit selects, active-low; bit i selects digit i.
- digits  out  4*NUM_DIGITS: decoded value, digit i at [4i+3:4i].
- digit_err  out  NUM_DIGITS: last capture of digit i was an unrecognised pattern.
- frame_valid  out  1: one-cycle pulse, every digit captured since the last pulse.
- display_off  out  1: no digit enabled for TIMEOUT_CYCLES.
- ghost_cnt  out  8: rejected-sample counter (see Configuration).

## Operation
- seg_in and digit_en_n pass through two flops each. Sync flops reset to all ones.
- Stability filter: stab_cnt clears when the synchronised {seg,en} differs from the previous cycle, otherwise it increments and saturates at STABLE_CYCLES-1.
- Capture fires once when stab_cnt reaches STABLE_CYCLES-1 and exactly one en bit is low. It does not repeat until the pattern changes.
- Decode, {g..a}→value:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4.
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
  - 1101111 (encoder fallback glyph)→4'hE.
  - 1111111 (blank)→4'hF.
- Any other pattern: set digit_err[i] and hold digits[i]. A recognised capture clears digit_err[i].
- Ghost rule: when the filter reaches the capture point with zero or ≥2 en bits low, nothing is captured and seen_mask is unaffected. With two or more bits low this is a ghost event.
- Frame: each capture sets seen_mask[i]. On the edge where the mask would become all ones, frame_valid←1 and seen_mask←0 on that same edge. frame_valid deasserts on the next edge.
- Idle: idle_cnt increments while all synchronised en bits are high and clears otherwise.
  - At TIMEOUT_CYCLES: display_off←1 and seen_mask←0; digits hold.
  - The first cycle with any en bit low clears display_off on the next edge.
- Reset values: digits all 4'hF, digit_err 0, frame_valid 0, display_off 0, ghost_cnt 0, seen_mask 0, stab_cnt 0, idle_cnt 0.
- Reset mid-capture: all state returns to reset values immediately. No partial frame survives.

## Timing
- Let edge N be the first edge sampling a new pin pattern. The synchronised value is visible after edge N+1.
- digits[i] and digit_err[i] update at edge N+1+STABLE_CYCLES.
- frame_valid is high in the cycle after the final-digit capture edge, for exactly one cycle.
- A pattern held for fewer than STABLE_CYCLES synchronised cycles is never captured.
- Re-capturing the same digit before the frame completes overwrites its value and leaves seen_mask unchanged.
- Re-capturing the same digit in the same cycle as a timeout: the timeout clears the mask and the capture still updates digits.

## Configuration
- SEVEN_SEGMENT_READER_GHOST_CNT_EN defined: ghost_cnt is an 8-bit counter, saturating at 255. It increments once per ghost event (capture point reached with ≥2 en bits low) and clears only on reset.
- Macro undefined: ghost_cnt is tied to 8'h00 and no counter logic is built. All other behaviour is identical.

## Test plan
- Reset, then scan digits 0..3 with 0010000, 0000010, 1111001, 1000000, 20 cycles each. Required: digits=16'h0169 (digit3…digit0), frame_valid pulses once, digit_err=0.
- Digit 2 shows 1101111, then 1111111, in separate frames. Required: digits[11:8]=E, then F; no error.
- Digit 1 shows 0101010. Required: digit_err[1]=1 and digits[7:4] holds its prior value. A following valid 3 clears the flag.
- Glitch held for STABLE_CYCLES-2 cycles between valid patterns. Required: no capture and no digits change.
- Two en bits low for 20 cycles, 300 times. Required: ghost_cnt=255 with the macro, 0 without; seen_mask unaffected.
- All en high for TIMEOUT_CYCLES with a partial frame in progress. Required: display_off=1 exactly at the timeout edge. A subsequent full scan pulses frame_valid only after all 4 digits are captured.
